// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready on both sides. Logic and shift ops finish one cycle after acceptance; MUL/DIV/MOD take WIDTH+1.
// in_ready is high only when idle. A result is held in DONE until out_ready is seen, and no new op is accepted on that edge.
module alu_seq #(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic [3:0]       flags
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_NOT  = 4'd5;
   localparam logic [3:0] OP_NAND = 4'd6;
   localparam logic [3:0] OP_NOR  = 4'd7;
   localparam logic [3:0] OP_XNOR = 4'd8;
   localparam logic [3:0] OP_SHL  = 4'd9;
   localparam logic [3:0] OP_SHR  = 4'd10;
   localparam logic [3:0] OP_SRA  = 4'd11;
   localparam logic [3:0] OP_ROL  = 4'd12;
   localparam logic [3:0] OP_MUL  = 4'd13;
   localparam logic [3:0] OP_DIV  = 4'd14;
   localparam logic [3:0] OP_MOD  = 4'd15;

   localparam logic [SHW-1:0] LAST_STEP = SHW'(WIDTH - 1);

   state_t r_state;
   state_t w_state_nxt;

   logic [3:0]         r_op;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [SHW-1:0]     r_cnt;
   logic [2*WIDTH-1:0] r_prod;
   logic [WIDTH-1:0]   r_rem;
   logic [WIDTH-1:0]   r_quo;
   logic [WIDTH-1:0]   r_out;
   logic [3:0]         r_flags;

   logic w_accept;
   logic w_multi;
   logic w_last;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      w_accept    = 1'b0;
      w_last      = 1'b0;
      w_multi     = (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = w_multi ? S_BUSY : S_DONE;
            end
         end
         S_BUSY: begin
            if (r_cnt == LAST_STEP) begin
               w_last      = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ------------------------------------------------- single-cycle ops
   logic [SHW-1:0]          w_amt;
   logic [WIDTH:0]          w_sum;
   logic [WIDTH:0]          w_dif;
   logic [WIDTH:0]          w_shl;
   logic [WIDTH:0]          w_shr;
   logic signed [WIDTH:0]   w_sra;
   logic [WIDTH-1:0]        w_rol;
   logic [WIDTH-1:0]        w_res;
   logic                    w_c;
   logic                    w_v;

   assign w_amt = in2[SHW-1:0];
   assign w_sum = {1'b0, in1} + {1'b0, in2};
   assign w_dif = {1'b0, in1} - {1'b0, in2};
   // Extra bit on the shifted-out side captures the last bit shifted out (0 for amount 0).
   assign w_shl = {1'b0, in1} << w_amt;
   assign w_shr = {in1, 1'b0} >> w_amt;
   assign w_sra = $signed({in1, 1'b0}) >>> w_amt;

   always_comb begin
      logic [SHW-1:0] w_src;
      w_rol = '0;
      w_src = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_src    = SHW'(i) - w_amt;
         w_rol[i] = in1[w_src];
      end
   end

   always_comb begin
      w_res = '0;
      w_c   = 1'b0;
      w_v   = 1'b0;
      case (op)
         OP_ADD: begin
            w_res = w_sum[WIDTH-1:0];
            w_c   = w_sum[WIDTH];
            w_v   = (in1[WIDTH-1] == in2[WIDTH-1]) && (w_sum[WIDTH-1] != in1[WIDTH-1]);
         end
         OP_SUB: begin
            w_res = w_dif[WIDTH-1:0];
            w_c   = w_dif[WIDTH];
            w_v   = (in1[WIDTH-1] != in2[WIDTH-1]) && (w_dif[WIDTH-1] != in1[WIDTH-1]);
         end
         OP_AND:  w_res = in1 & in2;
         OP_OR:   w_res = in1 | in2;
         OP_XOR:  w_res = in1 ^ in2;
         OP_NOT:  w_res = ~in1;
         OP_NAND: w_res = ~(in1 & in2);
         OP_NOR:  w_res = ~(in1 | in2);
         OP_XNOR: w_res = ~(in1 ^ in2);
         OP_SHL: begin
            w_res = w_shl[WIDTH-1:0];
            w_c   = w_shl[WIDTH];
         end
         OP_SHR: begin
            w_res = w_shr[WIDTH:1];
            w_c   = w_shr[0];
         end
         OP_SRA: begin
            w_res = w_sra[WIDTH:1];
            w_c   = w_sra[0];
         end
         OP_ROL:  w_res = w_rol;
         default: w_res = '0;
      endcase
   end

   // --------------------------------------------------- iterative ops
   logic [WIDTH:0]       w_psum;
   logic [2*WIDTH-1:0]   w_prod_nxt;
   logic [WIDTH:0]       w_rem_sh;
   logic                 w_fits;
   logic [WIDTH-1:0]     w_diff_lo;
   logic [WIDTH-1:0]     w_rem_nxt;
   logic [WIDTH-1:0]     w_quo_nxt;
   logic [WIDTH-1:0]     w_mres;
   logic                 w_mc;
   logic                 w_mv;

   // Multiply: high half accumulates the multiplicand, product shifts right past the multiplier bits.
   assign w_psum     = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, (r_prod[0] ? r_a : {WIDTH{1'b0}})};
   assign w_prod_nxt = {w_psum, r_prod[WIDTH-1:1]};

   // Restoring divide: a zero divisor always "fits", yielding all-ones quotient and remainder = dividend.
   assign w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
   assign w_fits    = (w_rem_sh >= {1'b0, r_b});
   assign w_diff_lo = w_rem_sh[WIDTH-1:0] - r_b;
   assign w_rem_nxt = w_fits ? w_diff_lo : w_rem_sh[WIDTH-1:0];
   assign w_quo_nxt = {r_quo[WIDTH-2:0], w_fits};

   always_comb begin
      w_mres = '0;
      w_mc   = 1'b0;
      w_mv   = 1'b0;
      case (r_op)
         OP_MUL: begin
            w_mres = w_prod_nxt[WIDTH-1:0];
            w_mc   = |w_prod_nxt[2*WIDTH-1:WIDTH];
         end
         OP_DIV: begin
            w_mres = w_quo_nxt;
            w_mv   = (r_b == '0);
         end
         OP_MOD: begin
            w_mres = w_rem_nxt;
            w_mv   = (r_b == '0);
         end
         default: w_mres = '0;
      endcase
   end

   // ---------------------------------------------------------- datapath
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_op    <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_cnt   <= '0;
         r_prod  <= '0;
         r_rem   <= '0;
         r_quo   <= '0;
         r_out   <= '0;
         r_flags <= '0;
      end else if (w_accept) begin
         r_op   <= op;
         r_a    <= in1;
         r_b    <= in2;
         r_cnt  <= '0;
         r_prod <= {{WIDTH{1'b0}}, in2};
         r_rem  <= '0;
         r_quo  <= in1;
         if (!w_multi) begin
            r_out   <= w_res;
            r_flags <= {w_v, w_c, w_res[WIDTH-1], (w_res == '0)};
         end
      end else if (r_state == S_BUSY) begin
         r_cnt  <= r_cnt + SHW'(1);
         r_prod <= w_prod_nxt;
         r_rem  <= w_rem_nxt;
         r_quo  <= w_quo_nxt;
         if (w_last) begin
            r_out   <= w_mres;
            r_flags <= {w_mv, w_mc, w_mres[WIDTH-1], (w_mres == '0)};
         end
      end
   end

   assign out   = r_out;
   assign flags = r_flags;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8; flags are {V,C,N,Z}.
module tb_alu_seq;

   localparam int W = 8;

   typedef struct packed {
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] r;
      logic [3:0]   f;
   } vec_t;

   logic         clk       = 1'b0;
   logic         rst_n     = 1'b0;
   logic         in_valid  = 1'b0;
   logic         out_ready = 1'b1;
   logic [3:0]   op        = '0;
   logic [W-1:0] in1       = '0;
   logic [W-1:0] in2       = '0;
   logic         in_ready;
   logic         out_valid;
   logic [W-1:0] out;
   logic [3:0]   flags;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .in1       (in1),
      .in2       (in2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .flags     (flags)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Drives one op, scrambles inputs after acceptance, returns latency and the result.
   task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output logic [W-1:0] r, output logic [3:0] f);
      int guard;
      guard    = 0;
      op       = o;
      in1      = a;
      in2      = b;
      in_valid = 1'b1;
      while (!in_ready && guard < 40) begin
         @(posedge clk); #1;
         guard++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      op       = ~o;
      in1      = ~a;
      in2      = ~b;
      lat      = 1;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      r = out;
      f = flags;
      @(posedge clk); #1;
   endtask

   task automatic run_table(input string name, input vec_t v[], input int exp_lat);
      int           lat;
      logic [W-1:0] r;
      logic [3:0]   f;
      foreach (v[i]) begin
         issue(v[i].op, v[i].a, v[i].b, lat, r, f);
         n_vec++;
         if (r !== v[i].r) begin
            n_err++;
            $display("FAIL %s[%0d] op=%0d out: got %02h want %02h", name, i, v[i].op, r, v[i].r);
         end
         n_vec++;
         if (f !== v[i].f) begin
            n_err++;
            $display("FAIL %s[%0d] op=%0d flags: got %04b want %04b", name, i, v[i].op, f, v[i].f);
         end
         n_vec++;
         if (lat !== exp_lat) begin
            n_err++;
            $display("FAIL %s[%0d] op=%0d latency: got %0d want %0d", name, i, v[i].op, lat, exp_lat);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_vec++;
      if (out !== 8'h00) begin n_err++; $display("FAIL reset_out: got %02h want 00", out); end
      n_vec++;
      if (flags !== 4'b0000) begin n_err++; $display("FAIL reset_flags: got %04b want 0000", flags); end
      n_vec++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_vec++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_arith();
      vec_t v[] = '{
         '{4'd0, 8'd200, 8'd100, 8'd44,  4'b0100},
         '{4'd1, 8'd170, 8'd60,  8'd110, 4'b1000},
         '{4'd1, 8'd5,   8'd7,   8'd254, 4'b0110},
         '{4'd0, 8'd127, 8'd1,   8'd128, 4'b1010},
         '{4'd0, 8'd0,   8'd0,   8'd0,   4'b0001}
      };
      run_table("arith", v, 1);
   endtask

   task automatic test_logic();
      vec_t v[] = '{
         '{4'd2, 8'hF0, 8'h3C, 8'h30, 4'b0000},
         '{4'd3, 8'hF0, 8'h0F, 8'hFF, 4'b0010},
         '{4'd4, 8'h5A, 8'h5A, 8'h00, 4'b0001},
         '{4'd5, 8'h0F, 8'h33, 8'hF0, 4'b0010},
         '{4'd6, 8'hFF, 8'hFF, 8'h00, 4'b0001},
         '{4'd7, 8'h00, 8'h00, 8'hFF, 4'b0010},
         '{4'd8, 8'hC3, 8'h0F, 8'h33, 4'b0000}
      };
      run_table("logic", v, 1);
   endtask

   task automatic test_shift();
      vec_t v[] = '{
         '{4'd11, 8'hAA, 8'd2, 8'hEA, 4'b0110},
         '{4'd9,  8'hAA, 8'd9, 8'h54, 4'b0100},
         '{4'd12, 8'h81, 8'd1, 8'h03, 4'b0000},
         '{4'd10, 8'h5A, 8'd0, 8'h5A, 4'b0000},
         '{4'd10, 8'h85, 8'd3, 8'h10, 4'b0100},
         '{4'd11, 8'h40, 8'd7, 8'h00, 4'b0101},
         '{4'd9,  8'h81, 8'd0, 8'h81, 4'b0010},
         '{4'd12, 8'h96, 8'd4, 8'h69, 4'b0000}
      };
      run_table("shift", v, 1);
   endtask

   task automatic test_muldiv();
      vec_t v[] = '{
         '{4'd13, 8'd15,  8'd17,  8'd255, 4'b0010},
         '{4'd13, 8'd16,  8'd17,  8'd16,  4'b0100},
         '{4'd13, 8'd0,   8'd200, 8'd0,   4'b0001},
         '{4'd13, 8'd255, 8'd255, 8'd1,   4'b0100},
         '{4'd14, 8'd170, 8'd60,  8'd2,   4'b0000},
         '{4'd15, 8'd170, 8'd60,  8'd50,  4'b0000},
         '{4'd14, 8'd170, 8'd0,   8'd255, 4'b1010},
         '{4'd15, 8'd170, 8'd0,   8'd170, 4'b1010},
         '{4'd14, 8'd255, 8'd1,   8'd255, 4'b0010},
         '{4'd15, 8'd7,   8'd200, 8'd7,   4'b0000},
         '{4'd14, 8'd7,   8'd200, 8'd0,   4'b0001}
      };
      run_table("muldiv", v, W + 1);
   endtask

   task automatic test_busy_ignores_input();
      int lat;
      int bad_rdy;
      op = 4'd13; in1 = 8'd15; in2 = 8'd17; in_valid = 1'b1;
      @(posedge clk); #1;
      lat     = 1;
      bad_rdy = 0;
      while (!out_valid && lat < 40) begin
         if (in_ready !== 1'b0) bad_rdy++;
         in_valid = lat[0];
         op  = 4'd0;
         in1 = 8'd1;
         in2 = 8'd1;
         @(posedge clk); #1;
         lat++;
      end
      in_valid = 1'b0;
      n_vec++;
      if (bad_rdy !== 0) begin n_err++; $display("FAIL busy_in_ready: got %0d high cycles want 0", bad_rdy); end
      n_vec++;
      if (lat !== W + 1) begin n_err++; $display("FAIL busy_latency: got %0d want %0d", lat, W + 1); end
      n_vec++;
      if (out !== 8'd255) begin n_err++; $display("FAIL busy_out: got %02h want ff", out); end
      n_vec++;
      if (flags !== 4'b0010) begin n_err++; $display("FAIL busy_flags: got %04b want 0010", flags); end
      @(posedge clk); #1;
      n_vec++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL busy_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_backpressure();
      int unstable;
      int lat;
      out_ready = 1'b0;
      op = 4'd0; in1 = 8'd3; in2 = 8'd4; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_vec++;
      if (out_valid !== 1'b1 || out !== 8'd7) begin
         n_err++;
         $display("FAIL bp_first: out_valid=%b out=%02h want 1 07", out_valid, out);
      end
      unstable = 0;
      for (int i = 0; i < 3; i++) begin
         in_valid = ~in_valid;
         in1      = 8'($urandom);
         in2      = 8'($urandom);
         op       = 4'($urandom);
         @(posedge clk); #1;
         if (out !== 8'd7 || flags !== 4'b0000 || out_valid !== 1'b1 || in_ready !== 1'b0) unstable++;
      end
      n_vec++;
      if (unstable !== 0) begin n_err++; $display("FAIL bp_hold: got %0d unstable cycles want 0", unstable); end
      // Release while a new op is offered: the release edge must not also accept it.
      out_ready = 1'b1;
      op = 4'd0; in1 = 8'd5; in2 = 8'd5; in_valid = 1'b1;
      @(posedge clk); #1;
      n_vec++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL bp_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      n_vec++;
      if (out_valid !== 1'b1 || out !== 8'd10) begin
         n_err++;
         $display("FAIL bp_reaccept: out_valid=%b out=%02h want 1 0a", out_valid, out);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_abort();
      int           stale;
      int           lat;
      logic [W-1:0] r;
      logic [3:0]   f;
      op = 4'd13; in1 = 8'd15; in2 = 8'd17; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      n_vec++;
      if (out !== 8'd0 || flags !== 4'b0000) begin
         n_err++;
         $display("FAIL abort_regs: out=%02h flags=%04b want 00 0000", out, flags);
      end
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL abort_hs: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
      end
      stale = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0) stale++;
      end
      n_vec++;
      if (stale !== 0) begin n_err++; $display("FAIL abort_stale: got %0d valid cycles want 0", stale); end
      issue(4'd0, 8'd1, 8'd1, lat, r, f);
      n_vec++;
      if (r !== 8'd2 || f !== 4'b0000 || lat !== 1) begin
         n_err++;
         $display("FAIL abort_next_add: out=%02h flags=%04b lat=%0d want 02 0000 1", r, f, lat);
      end
   endtask

   initial begin
      test_reset();
      test_arith();
      test_logic();
      test_shift();
      test_muldiv();
      test_busy_ignores_input();
      test_backpressure();
      test_reset_abort();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised sequential ALU, the successor of the current combinational 4-bit-opcode ALU. Adds a valid/ready handshake on both input and output, registered result and status flags, and multi-cycle iterative multiply, divide and modulo. It sits between an operand-issue stage and a writeback stage. One operation is in flight at a time.

Parameters:
WIDTH, 8, operand/result width in bits; must be a power of two and at least 4
SHW, $clog2(WIDTH), number of in2 LSBs used as the shift/rotate amount (derived; do not override)

Ports:
clk  input  1  clock; all state changes on the rising edge
rst_n  input  1  synchronous, active-low reset
in_valid  input  1  operation presented
in_ready  output  1  block can accept an operation
op  input  4  opcode
in1  input  WIDTH  operand A
in2  input  WIDTH  operand B
out_valid  output  1  result and flags valid
out_ready  input  1  consumer takes the result
out  output  WIDTH  registered result
flags  output  4  {V,C,N,Z}, registered with out

Behaviour:
- Reset: sampled on the clk edge while rst_n=0.
  - State -> IDLE; out=0; flags=0; out_valid=0; iteration counter=0.
  - in_ready=1 from the first edge with rst_n=1.
  - Reset in BUSY or DONE aborts the operation; no result is emitted.
- FSM states: IDLE, BUSY, DONE.
  - in_ready=1 only in IDLE.
  - out_valid=1 only in DONE.
- IDLE transitions, on an edge with in_valid=1:
  - Opcode is single-cycle: compute, register out/flags, go to DONE. Latency is 1 cycle from acceptance.
  - Opcode is 13, 14 or 15: latch operands and clear the counter. Go to BUSY.
- BUSY:
  - One shift-add (multiply) or restoring-subtract (divide/modulo) step per cycle, for WIDTH cycles.
  - Then register out/flags and go to DONE. Latency is WIDTH+1 cycles from acceptance.
  - in_valid is ignored.
- DONE:
  - out and flags stay stable until an edge with out_ready=1, then go to IDLE.
  - There is no same-cycle re-accept; the minimum issue interval is 2 cycles.
- Opcodes (unsigned unless noted):
  - 0 ADD; 1 SUB (in1-in2)
  - 2 AND; 3 OR; 4 XOR; 5 NOT in1; 6 NAND; 7 NOR; 8 XNOR
  - 9 SHL; 10 SHR (logical); 11 SRA (arithmetic); 12 ROL
  - 13 MUL (low WIDTH bits); 14 DIV (quotient); 15 MOD (remainder)
- Shift amount is in2[SHW-1:0], i.e. in2 mod WIDTH. An amount of 0 passes in1 unchanged.
- Flags:
  - Z = (out==0).
  - N = out[WIDTH-1].
  - C:
    - ADD: carry-out.
    - SUB: borrow (in1<in2).
    - SHL/SHR/SRA: last bit shifted out; 0 when the amount is 0.
    - MUL: high half of the 2*WIDTH product is nonzero.
    - All other opcodes: 0.
  - V:
    - ADD/SUB: signed two's-complement overflow.
    - DIV/MOD: in2==0.
    - All other opcodes: 0.
- Divide by zero still takes the full WIDTH+1 latency.
  - DIV returns all ones.
  - MOD returns in1.
- in1, in2 and op may change freely after acceptance. Results depend only on the values latched at acceptance.

Test Plan:
- WIDTH=8, reset then ADD in1=200 in2=100, out_ready=1 -> out_valid one cycle after acceptance; out=44, flags C=1 V=0 Z=0 N=0. Then SUB 170-60 -> out=110, C=0, V=1.
- MUL 15*17 -> out_valid exactly 9 cycles after acceptance; out=255, C=0, N=1. MUL 16*17 -> out=16, C=1. During BUSY, in_ready=0 and in_valid pulses are ignored.
- DIV 170/60 -> out=2. MOD 170%60 -> out=50. DIV 170/0 -> out=255, V=1. MOD 170%0 -> out=170, V=1.
- SRA 0xAA by in2=2 -> out=0xEA, C=1. SHL 0xAA by in2=9 (amount 1) -> out=0x54, C=1. ROL 0x81 by 1 -> out=0x03. SHR by 0 -> out=in1, C=0.
- Backpressure: ADD, then hold out_ready=0 for 3 cycles while toggling in1/in2/in_valid -> out/flags/out_valid stay constant and in_ready=0; first edge with out_ready=1 -> IDLE, in_ready=1.
- Start MUL, assert rst_n=0 for one cycle at BUSY cycle 4 -> out=0, flags=0, out_valid=0, in_ready=1 after release; no stale result. A following ADD 1+1 -> out=2.
